// File: rtl/guard_rst_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : guard_rst_ctrl_if
// Description : Signal bundle between the read/write guards, the monitored
//               slave and guard_rst_ctrl. The controller uses the slave
//               modport. The guard/slave side uses the master modport.
// Revision    : 1.0 - initial release
// ============================================================================
interface guard_rst_ctrl_if #(
  parameter int RST_CNT_WIDTH = 8
);
  logic                     rd_reset_req_i;
  logic                     wr_reset_req_i;
  logic                     slv_idle_i;
  logic                     irq_ack_i;
  logic                     isolate_o;
  logic                     slv_rst_o;
  logic                     reset_clear_o;
  logic                     busy_o;
  logic [1:0]               cause_o;
  logic [RST_CNT_WIDTH-1:0] rst_cnt_o;
  logic                     irq_o;

  modport slave (
    input  rd_reset_req_i, wr_reset_req_i, slv_idle_i, irq_ack_i,
    output isolate_o, slv_rst_o, reset_clear_o, busy_o, cause_o, rst_cnt_o, irq_o
  );

  modport master (
    output rd_reset_req_i, wr_reset_req_i, slv_idle_i, irq_ack_i,
    input  isolate_o, slv_rst_o, reset_clear_o, busy_o, cause_o, rst_cnt_o, irq_o
  );
endinterface
`default_nettype wire

// File: rtl/guard_rst_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : guard_rst_ctrl
// Description : Consumes reset requests from the read/write guards. It isolates
//               the slave, waits for drain, pulses the slave reset, recovers,
//               and then handshakes reset_clear back to the guards. It latches
//               the request cause and counts completed sequences (saturating).
//               Optional feature macro: GUARD_RST_CTRL_IRQ_EN (reset-event irq).
// Revision    : 1.0 - initial release
// ============================================================================
module guard_rst_ctrl #(
  parameter int ISO_CYCLES    = 16,
  parameter int RST_CYCLES    = 8,
  parameter int REC_CYCLES    = 4,
  parameter int TMR_WIDTH     = 8,
  parameter int RST_CNT_WIDTH = 8
) (
  input  logic               clk_i,
  input  logic               rst_i,
  guard_rst_ctrl_if.slave    bus
);

  localparam logic [TMR_WIDTH-1:0] c_iso_last = TMR_WIDTH'(ISO_CYCLES - 1);
  localparam logic [TMR_WIDTH-1:0] c_rst_last = TMR_WIDTH'(RST_CYCLES - 1);
  localparam logic [TMR_WIDTH-1:0] c_rec_last = TMR_WIDTH'(REC_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_ISOLATE = 3'd1,
    S_RESET   = 3'd2,
    S_RECOVER = 3'd3,
    S_CLEAR   = 3'd4
  } state_t;

  state_t                   r_state, w_state_nxt;
  logic [TMR_WIDTH-1:0]     r_tmr, w_tmr_nxt;
  logic [1:0]               r_cause, w_cause_nxt;
  logic [RST_CNT_WIDTH-1:0] r_rst_cnt, w_rst_cnt_nxt;
  logic                     r_isolate, r_slv_rst, r_reset_clear, r_busy;
  logic [1:0]               w_req_vec;
  logic                     w_req;
  logic                     w_start;

  assign w_req_vec = {bus.wr_reset_req_i, bus.rd_reset_req_i};
  assign w_req     = |w_req_vec;

  // Next-state, phase timer, cause and counter updates.
  always_comb begin
    w_state_nxt   = r_state;
    w_tmr_nxt     = r_tmr;
    w_cause_nxt   = r_cause;
    w_rst_cnt_nxt = r_rst_cnt;
    w_start       = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_req) begin
          w_state_nxt = S_ISOLATE;
          w_tmr_nxt   = '0;
          w_cause_nxt = w_req_vec;
          w_start     = 1'b1;
        end
      end
      S_ISOLATE: begin
        w_cause_nxt = r_cause | w_req_vec;
        if (bus.slv_idle_i || (r_tmr == c_iso_last)) begin
          w_state_nxt = S_RESET;
          w_tmr_nxt   = '0;
        end else begin
          w_tmr_nxt = r_tmr + 1'b1;
        end
      end
      S_RESET: begin
        if (r_tmr == c_rst_last) begin
          w_state_nxt = S_RECOVER;
          w_tmr_nxt   = '0;
        end else begin
          w_tmr_nxt = r_tmr + 1'b1;
        end
      end
      S_RECOVER: begin
        if (r_tmr == c_rec_last) begin
          w_state_nxt = S_CLEAR;
          w_tmr_nxt   = '0;
        end else begin
          w_tmr_nxt = r_tmr + 1'b1;
        end
      end
      S_CLEAR: begin
        // Guards must drop their requests before the sequence is complete.
        if (!w_req) begin
          w_state_nxt = S_IDLE;
          if (r_rst_cnt != {RST_CNT_WIDTH{1'b1}}) begin
            w_rst_cnt_nxt = r_rst_cnt + 1'b1;
          end
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_tmr_nxt   = '0;
      end
    endcase
  end

  // State register; outputs are registered decodes of the next state.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state       <= S_IDLE;
      r_tmr         <= '0;
      r_cause       <= '0;
      r_rst_cnt     <= '0;
      r_isolate     <= 1'b0;
      r_slv_rst     <= 1'b0;
      r_reset_clear <= 1'b0;
      r_busy        <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_tmr         <= w_tmr_nxt;
      r_cause       <= w_cause_nxt;
      r_rst_cnt     <= w_rst_cnt_nxt;
      r_isolate     <= (w_state_nxt != S_IDLE);
      r_slv_rst     <= (w_state_nxt == S_RESET);
      r_reset_clear <= (w_state_nxt == S_CLEAR);
      r_busy        <= (w_state_nxt != S_IDLE);
    end
  end

  assign bus.isolate_o     = r_isolate;
  assign bus.slv_rst_o     = r_slv_rst;
  assign bus.reset_clear_o = r_reset_clear;
  assign bus.busy_o        = r_busy;
  assign bus.cause_o       = r_cause;
  assign bus.rst_cnt_o     = r_rst_cnt;

`ifdef GUARD_RST_CTRL_IRQ_EN
  logic r_irq;

  // Interrupt is set when a sequence starts. Set has priority over acknowledge.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_irq <= 1'b0;
    end else if (w_start) begin
      r_irq <= 1'b1;
    end else if (bus.irq_ack_i) begin
      r_irq <= 1'b0;
    end
  end

  assign bus.irq_o = r_irq;
`else
  logic w_unused_irq_ack;
  assign w_unused_irq_ack = bus.irq_ack_i;
  assign bus.irq_o        = 1'b0;
`endif

`ifndef SYNTHESIS
  initial begin
    if (ISO_CYCLES < 1 || ISO_CYCLES > (1 << TMR_WIDTH))
      $error("guard_rst_ctrl: ISO_CYCLES out of range");
    if (RST_CYCLES < 1 || RST_CYCLES > (1 << TMR_WIDTH))
      $error("guard_rst_ctrl: RST_CYCLES out of range");
    if (REC_CYCLES < 1 || REC_CYCLES > (1 << TMR_WIDTH))
      $error("guard_rst_ctrl: REC_CYCLES out of range");
  end

  a_slv_rst_only_in_reset: assert property (@(posedge clk_i) disable iff (rst_i)
    r_slv_rst |-> (r_state == S_RESET && r_isolate));
`endif

endmodule
`default_nettype wire

// File: tb/tb_guard_rst_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_guard_rst_ctrl
// Description : Directed self-checking bench for guard_rst_ctrl (16/8/4 phase
//               lengths, 2-bit event counter so saturation is reachable).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_guard_rst_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_vec = 0;
  int   n_err = 0;
  int   cyc   = 0;
  int   t_req = 0;
  int   rel;
  int   t_mark;

  guard_rst_ctrl_if #(.RST_CNT_WIDTH(2)) bus_if ();

  guard_rst_ctrl #(
    .ISO_CYCLES   (16),
    .RST_CYCLES   (8),
    .REC_CYCLES   (4),
    .TMR_WIDTH    (8),
    .RST_CNT_WIDTH(2)
  ) dut (
    .clk_i(clk),
    .rst_i(rst),
    .bus  (bus_if)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic tick_n(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  function automatic logic sel_sig(input int sel);
    case (sel)
      0:       return bus_if.slv_rst_o == 1'b1;
      1:       return bus_if.reset_clear_o == 1'b1;
      2:       return bus_if.slv_rst_o == 1'b0;
      default: return bus_if.busy_o == 1'b0;
    endcase
  endfunction

  // Bounded wait; rel is the time relative to the request edge T.
  task automatic wait_sig(input string tag, input int sel, input int budget, output int r);
    int n = 0;
    while (!sel_sig(sel) && n < budget) begin
      tick();
      n++;
    end
    check({tag, "_reached"}, 32'(sel_sig(sel)), 32'd1);
    r = cyc - t_req;
  endtask

  // Present a request so that the next edge is edge T.
  task automatic start_req(input logic rd, input logic wr);
    bus_if.rd_reset_req_i = rd;
    bus_if.wr_reset_req_i = wr;
    t_req = cyc;
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    bus_if.rd_reset_req_i = 1'b0;
    bus_if.wr_reset_req_i = 1'b0;
    bus_if.slv_idle_i     = 1'b0;
    bus_if.irq_ack_i      = 1'b0;
    rst = 1'b1;
    tick_n(2);
    rst = 1'b0;

    // Reset state
    check("rst_flags", {bus_if.isolate_o, bus_if.slv_rst_o, bus_if.reset_clear_o, bus_if.busy_o}, 4'b0000);
    check("rst_cause", bus_if.cause_o, 2'b00);
    check("rst_cnt", bus_if.rst_cnt_o, 2'd0);
    check("rst_irq", bus_if.irq_o, 1'b0);
    tick();

    // A: read timeout, slow drain
    start_req(1'b1, 1'b0);
    bus_if.rd_reset_req_i = 1'b0;
    check("A_isolate_T1", bus_if.isolate_o, 1'b1);
    check("A_busy_T1", bus_if.busy_o, 1'b1);
    check("A_cause", bus_if.cause_o, 2'b01);
`ifdef GUARD_RST_CTRL_IRQ_EN
    check("A_irq_set", bus_if.irq_o, 1'b1);
`else
    check("A_irq_tied", bus_if.irq_o, 1'b0);
`endif
    wait_sig("A_slv_rst_rise", 0, 40, rel);
    check("A_slv_rst_rise_time", rel, 17);
    t_mark = cyc;
    wait_sig("A_slv_rst_fall", 2, 20, rel);
    check("A_slv_rst_len", cyc - t_mark, 8);
    wait_sig("A_clr_rise", 1, 20, rel);
    check("A_clr_rise_time", rel, 29);
    check("A_isolate_in_clear", bus_if.isolate_o, 1'b1);
    tick();
    check("A_idle_flags", {bus_if.isolate_o, bus_if.reset_clear_o, bus_if.busy_o}, 3'b000);
    check("A_cnt", bus_if.rst_cnt_o, 2'd1);
    check("A_cause_kept", bus_if.cause_o, 2'b01);
`ifdef GUARD_RST_CTRL_IRQ_EN
    check("A_irq_held", bus_if.irq_o, 1'b1);
    bus_if.irq_ack_i = 1'b1;
    tick();
    bus_if.irq_ack_i = 1'b0;
    check("A_irq_acked", bus_if.irq_o, 1'b0);
`endif

    // B: write request, early drain
    start_req(1'b0, 1'b1);
    bus_if.wr_reset_req_i = 1'b0;
    check("B_cause", bus_if.cause_o, 2'b10);
`ifdef GUARD_RST_CTRL_IRQ_EN
    check("B_irq_reset", bus_if.irq_o, 1'b1);
`endif
    tick_n(2);
    bus_if.slv_idle_i = 1'b1;
    tick();
    bus_if.slv_idle_i = 1'b0;
    check("B_slv_rst_early", bus_if.slv_rst_o, 1'b1);
    check("B_slv_rst_time", cyc - t_req, 4);
    wait_sig("B_done", 3, 40, rel);
    check("B_cnt", bus_if.rst_cnt_o, 2'd2);

    // C: simultaneous read and write requests
    start_req(1'b1, 1'b1);
    bus_if.rd_reset_req_i = 1'b0;
    bus_if.wr_reset_req_i = 1'b0;
    check("C_cause", bus_if.cause_o, 2'b11);
    wait_sig("C_slv_rst_rise", 0, 40, rel);
    t_mark = cyc;
    wait_sig("C_slv_rst_fall", 2, 20, rel);
    check("C_slv_rst_len", cyc - t_mark, 8);
    wait_sig("C_done", 3, 40, rel);
    check("C_cnt", bus_if.rst_cnt_o, 2'd3);
    tick_n(20);
    check("C_single_seq", {bus_if.slv_rst_o, bus_if.busy_o}, 2'b00);

    // E: reset asserted in the 3rd cycle of the slave reset pulse
    start_req(1'b1, 1'b0);
    bus_if.rd_reset_req_i = 1'b0;
    wait_sig("E_slv_rst_rise", 0, 40, rel);
    tick_n(2);
    check("E_pulse_active", bus_if.slv_rst_o, 1'b1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("E_flags", {bus_if.slv_rst_o, bus_if.isolate_o, bus_if.busy_o, bus_if.reset_clear_o}, 4'b0000);
    check("E_cnt", bus_if.rst_cnt_o, 2'd0);
    check("E_cause", bus_if.cause_o, 2'b00);
    check("E_irq", bus_if.irq_o, 1'b0);
    tick();

    // D: read held through the sequence, write ORs in during isolation, held 5 cycles in CLEAR
    start_req(1'b1, 1'b0);
    tick();
    bus_if.wr_reset_req_i = 1'b1;
    tick();
    bus_if.wr_reset_req_i = 1'b0;
    check("D_cause_or", bus_if.cause_o, 2'b11);
    wait_sig("D_clr_rise", 1, 60, rel);
    for (int i = 0; i < 4; i++) begin
      tick();
      check($sformatf("D_clr_hold%0d", i), bus_if.reset_clear_o, 1'b1);
    end
    bus_if.rd_reset_req_i = 1'b0;
    tick();
    check("D_idle_flags", {bus_if.reset_clear_o, bus_if.busy_o, bus_if.isolate_o}, 3'b000);
    check("D_cnt", bus_if.rst_cnt_o, 2'd1);
    start_req(1'b1, 1'b0);
    bus_if.rd_reset_req_i = 1'b0;
    check("D_restart_busy", bus_if.busy_o, 1'b1);
    check("D_restart_cause", bus_if.cause_o, 2'b01);
    bus_if.slv_idle_i = 1'b1;
    wait_sig("D_restart_done", 3, 40, rel);
    bus_if.slv_idle_i = 1'b0;
    check("D_cnt2", bus_if.rst_cnt_o, 2'd2);

    // Saturation: three more sequences on a 2-bit counter
    for (int s = 0; s < 3; s++) begin
`ifdef GUARD_RST_CTRL_IRQ_EN
      if (s == 0) bus_if.irq_ack_i = 1'b1;
`endif
      start_req(1'b0, 1'b1);
      bus_if.wr_reset_req_i = 1'b0;
      bus_if.irq_ack_i = 1'b0;
`ifdef GUARD_RST_CTRL_IRQ_EN
      check($sformatf("S_irq_set%0d", s), bus_if.irq_o, 1'b1);
`endif
      bus_if.slv_idle_i = 1'b1;
      wait_sig($sformatf("S_done%0d", s), 3, 40, rel);
      bus_if.slv_idle_i = 1'b0;
      check($sformatf("S_cnt%0d", s), bus_if.rst_cnt_o, 2'd3);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/guard_rst_ctrl.md
Name: guard_rst_ctrl

Overview:
- Downstream consumer of the read and write guards' reset requests. It sits between the guards and the monitored AXI slave.
- On a timeout-driven reset request it isolates the slave, waits for a drain window, and drives a fixed-length slave reset pulse.
- After a recovery window it handshakes reset_clear back to both guards, then returns to idle.
- It also latches the cause and counts reset events for the regbus.

Parameters:
- IsoCycles, 16, maximum cycles in ISOLATE waiting for slave drain (>=1).
- RstCycles, 8, exact cycles slv_rst_o is held high (>=1).
- RecCycles, 4, cycles of isolation after reset release before clearing the guards (>=1).
- TmrWidth, 8, width of the internal phase timer; each of IsoCycles, RstCycles, RecCycles must be <= 2**TmrWidth.
- RstCntWidth, 8, width of the saturating reset-event counter.

Ports:
- clk_i, in, 1, clock.
- rst_i, in, 1, synchronous active-high reset.
- rd_reset_req_i, in, 1, reset request from the read guard (level).
- wr_reset_req_i, in, 1, reset request from the write guard (level).
- slv_idle_i, in, 1, slave has no outstanding beats (early drain exit).
- isolate_o, out, 1, gate master requests and force error responses toward the master.
- slv_rst_o, out, 1, active-high slave reset.
- reset_clear_o, out, 1, clear request to both guards.
- busy_o, out, 1, FSM not in IDLE.
- cause_o, out, 2, latched cause: bit0 read, bit1 write.
- rst_cnt_o, out, RstCntWidth, number of completed reset sequences, saturating.
- irq_ack_i, in, 1, clears irq_o (optional feature only).
- irq_o, out, 1, reset-event interrupt (optional feature only).

Behaviour:
- Clock and reset: one clock clk_i; reset rst_i is synchronous and active-high.
- Registered outputs: all outputs come from registers.
- Reset values: state IDLE; timer 0; isolate_o, slv_rst_o, reset_clear_o, busy_o, irq_o = 0; cause_o = 0; rst_cnt_o = 0.
- Reset mid-sequence: rst_i asserted in any state returns to IDLE at the next edge with all outputs at reset values. slv_rst_o drops immediately, even mid-pulse.
- Request: req = rd_reset_req_i | wr_reset_req_i.
- IDLE:
  - If req is high at edge T, then at T+1: state ISOLATE, isolate_o=1, busy_o=1, timer=0.
  - cause_o = {wr_reset_req_i, rd_reset_req_i} as sampled at T.
- ISOLATE:
  - cause_o ORs in any newly asserted request bit.
  - The timer increments each cycle.
  - Exit to RESET on the edge where slv_idle_i=1, or where timer==IsoCycles-1, whichever comes first. Dwell is 1..IsoCycles cycles.
  - Entering RESET: slv_rst_o=1, timer=0.
- RESET:
  - slv_rst_o is high for exactly RstCycles cycles, then RECOVER with slv_rst_o=0 and timer=0.
  - isolate_o stays 1.
  - Request inputs are ignored.
- RECOVER:
  - Exactly RecCycles cycles with isolate_o=1.
  - Then CLEAR with reset_clear_o=1.
- CLEAR:
  - reset_clear_o is held high while either request is high.
  - On the first edge where both requests are low: IDLE, reset_clear_o=0, isolate_o=0, busy_o=0.
  - rst_cnt_o increments by 1 on that same edge, saturating at all-ones (no wrap).
  - cause_o retains its value until the next IDLE->ISOLATE transition.
- Simultaneous requests: rd and wr in the same IDLE cycle give cause_o=2'b11 and a single sequence.
- Requests during RESET/RECOVER/CLEAR do not start a second sequence. A request still high after the CLEAR handshake completes re-enters ISOLATE from IDLE on the following edge.
- Phase timer: compares against Parameter-1 at TmrWidth; never wraps within a phase.
- Simulation-only checks:
  - Parameter ranges are validated in an initial block.
  - An assertion checks that slv_rst_o is never high outside RESET and that isolate_o is high whenever slv_rst_o is high.

Optional Feature:
- Macro: GUARD_RST_CTRL_IRQ_EN.
- When defined:
  - irq_o is set on the IDLE->ISOLATE edge and stays high until irq_ack_i is sampled high.
  - If set and ack occur on the same edge, set wins.
  - irq_o is cleared by rst_i.
- When not defined:
  - irq_o is tied 0.
  - irq_ack_i is unused.
  - No irq register is inferred.

Test Plan:
- Read timeout, slow drain: rd_reset_req_i=1 for 1 cycle at T, slv_idle_i=0.
  - isolate_o rises at T+1; slv_rst_o high T+17..T+24 (8 cycles); reset_clear_o rises at T+29.
  - cause_o=2'b01; rst_cnt_o=1 after the handshake.
- Early drain: wr_reset_req_i high, slv_idle_i=1 at T+3 -> slv_rst_o rises at T+4; cause_o=2'b10.
- Simultaneous rd+wr requests: cause_o=2'b11, exactly one 8-cycle slv_rst_o pulse, rst_cnt_o increments by 1.
- Clear handshake: rd_reset_req_i held high 5 cycles into CLEAR -> reset_clear_o held for those 5 cycles, then IDLE one cycle after rd drops.
  - Request re-asserted in IDLE -> new sequence, rst_cnt_o=2.
- Mid-pulse reset: rst_i at 3rd cycle of RESET -> next edge: slv_rst_o=0, isolate_o=0, busy_o=0, rst_cnt_o=0.
- Saturation and IRQ: RstCntWidth=2, run 5 sequences -> rst_cnt_o stays 3.
  - With GUARD_RST_CTRL_IRQ_EN: irq_o rises at T+1, stays high until irq_ack_i pulse, and re-sets on the next sequence.
